// File: rtl/mdu_iter_if.sv
// ---------------------------------------------------------------------------
// mdu_iter_if
//   Bundle between the EXE stage and the iterative multiply/divide unit.
//   master : EXE stage side (drives request, operands, flush, MTHI/MTLO)
//   slave  : mdu_iter side (returns busy/done and the architectural HI/LO)
// Signals:
//   EXE_MDU_Req / EXE_MDU_Op      start request and operation code
//   EXE_ResultA / EXE_ResultB     rs / rt operands
//   EXE_Flush                     cancel of an operation in flight
//   EXE_HI_We / EXE_LO_We         MTHI / MTLO enables, EXE_HILO_Wdata data
//   EXE_MDU_Busy / EXE_MDU_Done   stall request and one-cycle completion
//   EXE_HI / EXE_LO               registered HI / LO
// ---------------------------------------------------------------------------
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             EXE_MDU_Req;
    logic [2:0]       EXE_MDU_Op;
    logic [WIDTH-1:0] EXE_ResultA;
    logic [WIDTH-1:0] EXE_ResultB;
    logic             EXE_Flush;
    logic             EXE_HI_We;
    logic             EXE_LO_We;
    logic [WIDTH-1:0] EXE_HILO_Wdata;
    logic             EXE_MDU_Busy;
    logic             EXE_MDU_Done;
    logic [WIDTH-1:0] EXE_HI;
    logic [WIDTH-1:0] EXE_LO;

    modport master (
        output EXE_MDU_Req, EXE_MDU_Op, EXE_ResultA, EXE_ResultB, EXE_Flush,
               EXE_HI_We, EXE_LO_We, EXE_HILO_Wdata,
        input  EXE_MDU_Busy, EXE_MDU_Done, EXE_HI, EXE_LO
    );

    modport slave (
        input  EXE_MDU_Req, EXE_MDU_Op, EXE_ResultA, EXE_ResultB, EXE_Flush,
               EXE_HI_We, EXE_LO_We, EXE_HILO_Wdata,
        output EXE_MDU_Busy, EXE_MDU_Done, EXE_HI, EXE_LO
    );
endinterface

// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
//   Iterative radix-2 multiply / divide / multiply-accumulate unit that owns
//   the architectural HI/LO registers. One operation at a time, sequenced
//   IDLE -> ITER (WIDTH steps) -> FIX (sign/accumulate, HI/LO write) -> DONE.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   mdu  : mdu_iter_if slave modport (request, operands, flush, MTHI/MTLO,
//          busy/done handshake, HI/LO)
// Op codes: 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB 7 MSUBU
// ---------------------------------------------------------------------------
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave mdu
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   hi_q, lo_q;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient
    //            bits shifting in}. Divide by zero parks raw ResultA in the
    //            low half so FIX can return it as HI.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [2:0]         op_q;
    logic               neg_res_q;   // product / quotient must be negated
    logic               neg_rem_q;   // remainder takes the dividend's sign
    logic               div0_q;
    logic [CNT_W-1:0]   cnt_q;

    logic busy, done, commit;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             in_signed, in_div, a_neg, b_neg, b_zero, start;
    logic [WIDTH-1:0] mag_a, mag_b;

    // NOTE: every variable of an always_comb gets a value on every path
    // (defaults first where there are branches), otherwise a latch appears.
    always_comb begin
        in_signed = ~mdu.EXE_MDU_Op[0];
        in_div    = (mdu.EXE_MDU_Op[2:1] == 2'b01);
        a_neg     = in_signed & mdu.EXE_ResultA[WIDTH-1];
        b_neg     = in_signed & mdu.EXE_ResultB[WIDTH-1];
        b_zero    = (mdu.EXE_ResultB == '0);
        mag_a     = a_neg ? -mdu.EXE_ResultA : mdu.EXE_ResultA;
        mag_b     = b_neg ? -mdu.EXE_ResultB : mdu.EXE_ResultB;
        start     = (state_q == S_IDLE) & mdu.EXE_MDU_Req & ~mdu.EXE_Flush;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (in_div && b_zero) ? S_FIX : S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (mdu.EXE_Flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy = 1'b1;
                // A flush here cancels the HI/LO write together with Done.
                if (mdu.EXE_Flush) begin
                    state_d = S_IDLE;
                end else begin
                    commit  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One radix-2 iteration
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        // Shift-add: add multiplicand on the multiplier LSB, then shift right.
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + ({1'b0, opnd_q} & {(WIDTH+1){work_q[0]}});
        // Restoring divide: bring the next dividend bit into the remainder.
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opnd_q});
        // When the divisor fits, the true difference is below 2^WIDTH, so
        // modulo-2^WIDTH subtraction is exact.
        div_rem   = div_fits ? (div_shift[WIDTH-1:0] - opnd_q)
                             : div_shift[WIDTH-1:0];
        if (op_q[2:1] == 2'b01) begin
            work_d = {div_rem, work_q[WIDTH-2:0], div_fits};
        end else begin
            work_d = {mul_sum, work_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and accumulate (evaluated in FIX)
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_s, acc, fix_res;
    logic [WIDTH-1:0]   quo_s, rem_s;

    always_comb begin
        prod_s = neg_res_q ? -work_q : work_q;
        acc    = {hi_q, lo_q};
        quo_s  = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem_s  = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
        if (div0_q) begin
            fix_res = {work_q[WIDTH-1:0], {WIDTH{1'b1}}};
        end else if (op_q[2:1] == 2'b01) begin
            fix_res = {rem_s, quo_s};
        end else if (op_q[2]) begin
            fix_res = op_q[1] ? (acc - prod_s) : (acc + prod_s);
        end else begin
            fix_res = prod_s;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q    <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (start) begin
            op_q      <= mdu.EXE_MDU_Op;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= in_div & b_zero;
            cnt_q     <= '0;
            if (in_div) begin
                opnd_q <= mag_b;
                work_q <= {{WIDTH{1'b0}}, b_zero ? mdu.EXE_ResultA : mag_a};
            end else begin
                opnd_q <= mag_a;
                work_q <= {{WIDTH{1'b0}}, mag_b};
            end
        end else if (state_q == S_ITER) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // HI/LO: result commit on FIX exit, MTHI/MTLO only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            {hi_q, lo_q} <= fix_res;
        end else if (state_q == S_IDLE) begin
            if (mdu.EXE_HI_We) hi_q <= mdu.EXE_HILO_Wdata;
            if (mdu.EXE_LO_We) lo_q <= mdu.EXE_HILO_Wdata;
        end
    end

    assign mdu.EXE_MDU_Busy = busy;
    assign mdu.EXE_MDU_Done = done;
    assign mdu.EXE_HI       = hi_q;
    assign mdu.EXE_LO       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// ---------------------------------------------------------------------------
// tb_mdu_iter
//   Self-checking bench for mdu_iter at WIDTH = 32: a table of directed
//   vectors with hand-computed results, randomized operations checked
//   against a 64-bit arithmetic reference model, and hand-written
//   sequences for flush, back-to-back and asynchronous reset corners.
// ---------------------------------------------------------------------------
module tb_mdu_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_hi, m_lo;   // expected architectural HI/LO

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int           cyc;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    // and the remainder keeps the dividend's sign.
    function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] hi,
                                             input logic [W-1:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        acc = {hi, lo};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2, 3'd3: begin
                if (b == '0) return {a, {W{1'b1}}};
                if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[W-1:0], q[W-1:0]};
            end
            3'd4: return acc + 64'(sa * sb);
            3'd5: return acc + ua * ub;
            3'd6: return acc - 64'(sa * sb);
            default: return acc - ua * ub;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic mt(input bit to_hi, input logic [W-1:0] d);
        bus.EXE_HI_We      = to_hi;
        bus.EXE_LO_We      = !to_hi;
        bus.EXE_HILO_Wdata = d;
        @(posedge clk); #1;
        bus.EXE_HI_We = 1'b0;
        bus.EXE_LO_We = 1'b0;
        if (to_hi) begin
            m_hi = d;
            check("mthi", bus.EXE_HI, d);
        end else begin
            m_lo = d;
            check("mtlo", bus.EXE_LO, d);
        end
    endtask

    // Leaves the bench #1 into cycle 1 (acceptance edge is cycle 0).
    task automatic start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.EXE_MDU_Req = 1'b1;
        bus.EXE_MDU_Op  = op;
        bus.EXE_ResultA = a;
        bus.EXE_ResultB = b;
        @(posedge clk); #1;
        bus.EXE_MDU_Req = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.EXE_MDU_Done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic watch_no_done(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            if (bus.EXE_MDU_Done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        check(name, seen, 0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input int exp_cyc);
        int cyc;
        start(op, a, b);
        // Operands change right after acceptance; the unit must have latched them.
        bus.EXE_ResultA = W'($urandom);
        bus.EXE_ResultB = W'($urandom);
        bus.EXE_MDU_Op  = 3'($urandom);
        check({name, ".busy1"}, bus.EXE_MDU_Busy, 1);
        wait_done(cyc);
        check({name, ".cycle"}, cyc, exp_cyc);
        check({name, ".busy_done"}, bus.EXE_MDU_Busy, 1);
        check({name, ".hilo"}, {bus.EXE_HI, bus.EXE_LO}, exp);
        {m_hi, m_lo} = exp;
        @(posedge clk); #1;
        check({name, ".idle"}, {bus.EXE_MDU_Busy, bus.EXE_MDU_Done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int           cyc;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [2*W-1:0] exp;

        //          op     a              b              pre_hi         pre_lo         exp_hi         exp_lo         cyc
        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0,         32'h0,         32'h0000_0001, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd3, 32'd100,       32'd7,         32'h0,         32'h0,         32'd2,         32'd14,        34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         32'h8000_0000, 34};
        vecs[5]  = '{3'd5, 32'd1,         32'd1,         32'h0,         32'hFFFF_FFFF, 32'd1,         32'h0,         34};
        vecs[6]  = '{3'd6, 32'd1,         32'd2,         32'd1,         32'h0,         32'h0,         32'hFFFF_FFFE, 34};
        vecs[7]  = '{3'd3, 32'h1234_5678, 32'h0,         32'h0,         32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 2};
        vecs[8]  = '{3'd2, 32'hFFFF_FFFB, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 2};
        vecs[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0,         32'h0,         32'd1,         32'hFFFF_FFFD, 34};
        vecs[10] = '{3'd4, 32'hFFFF_FFFD, 32'd4,         32'h0,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 34};
        vecs[11] = '{3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0000_0001, 32'hFFFF_FFFF, 34};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'd10,        32'h0,         32'h0,         32'd5,         32'h1999_9999, 34};

        bus.EXE_MDU_Req    = 1'b0;
        bus.EXE_MDU_Op     = '0;
        bus.EXE_ResultA    = '0;
        bus.EXE_ResultB    = '0;
        bus.EXE_Flush      = 1'b0;
        bus.EXE_HI_We      = 1'b0;
        bus.EXE_LO_We      = 1'b0;
        bus.EXE_HILO_Wdata = '0;
        m_hi = '0;
        m_lo = '0;

        // Reset state
        rst = 1'b1;
        #2;
        check("reset", {bus.EXE_MDU_Busy, bus.EXE_MDU_Done, bus.EXE_HI, bus.EXE_LO}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            mt(1'b1, vecs[i].pre_hi);
            mt(1'b0, vecs[i].pre_lo);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].exp_hi, vecs[i].exp_lo}, vecs[i].cyc);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mt(1'b1, W'($urandom));
                mt(1'b0, W'($urandom));
            end
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = model(op, a, b, m_hi, m_lo);
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, exp,
                   (op[2:1] == 2'b01 && b == '0) ? 2 : 34);
        end

        // Flush during ITER (cycle 10)
        mt(1'b1, 32'h0000_AAAA);
        mt(1'b0, 32'h0000_5555);
        start(3'd0, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        bus.EXE_Flush = 1'b1;
        @(posedge clk); #1;
        bus.EXE_Flush = 1'b0;
        check("flush_iter.busy", bus.EXE_MDU_Busy, 0);
        check("flush_iter.hilo", {bus.EXE_HI, bus.EXE_LO}, 64'h0000_AAAA_0000_5555);
        watch_no_done("flush_iter.no_done", 40);

        // Flush during FIX (cycle 33)
        start(3'd0, 32'd3, 32'd5);
        repeat (32) begin @(posedge clk); #1; end
        check("flush_fix.pre_busy", bus.EXE_MDU_Busy, 1);
        bus.EXE_Flush = 1'b1;
        @(posedge clk); #1;
        bus.EXE_Flush = 1'b0;
        check("flush_fix.busy", bus.EXE_MDU_Busy, 0);
        watch_no_done("flush_fix.no_done", 40);
        check("flush_fix.hilo", {bus.EXE_HI, bus.EXE_LO}, 64'h0000_AAAA_0000_5555);

        // Flush in DONE has no effect
        start(3'd1, 32'd6, 32'd7);
        wait_done(cyc);
        bus.EXE_Flush = 1'b1;
        check("flush_done.hilo", {bus.EXE_HI, bus.EXE_LO}, 64'd42);
        @(posedge clk); #1;
        bus.EXE_Flush = 1'b0;
        check("flush_done.after", {bus.EXE_MDU_Busy, bus.EXE_HI, bus.EXE_LO}, 64'd42);
        m_hi = '0;
        m_lo = 32'd42;

        // Req together with Flush in IDLE is dropped
        bus.EXE_MDU_Req = 1'b1;
        bus.EXE_Flush   = 1'b1;
        bus.EXE_MDU_Op  = 3'd0;
        @(posedge clk); #1;
        bus.EXE_MDU_Req = 1'b0;
        bus.EXE_Flush   = 1'b0;
        check("req_flush.busy", bus.EXE_MDU_Busy, 0);
        watch_no_done("req_flush.no_done", 40);

        // Back-to-back: Req held from the DONE cycle is taken in IDLE (cycle 35)
        start(3'd1, 32'd7, 32'd9);
        wait_done(cyc);
        check("b2b.first", {bus.EXE_HI, bus.EXE_LO}, 64'd63);
        bus.EXE_MDU_Req = 1'b1;
        bus.EXE_MDU_Op  = 3'd1;
        bus.EXE_ResultA = 32'd2;
        bus.EXE_ResultB = 32'd3;
        @(posedge clk); #1;
        check("b2b.idle_gap", bus.EXE_MDU_Busy, 0);
        @(posedge clk); #1;
        bus.EXE_MDU_Req = 1'b0;
        check("b2b.second_busy", bus.EXE_MDU_Busy, 1);
        wait_done(cyc);
        check("b2b.second_cycle", cyc, 34);
        check("b2b.second", {bus.EXE_HI, bus.EXE_LO}, 64'd6);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a DIV
        mt(1'b1, 32'h0000_1234);
        mt(1'b0, 32'h0000_5678);
        start(3'd2, 32'd1000, 32'd3);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("async_rst", {bus.EXE_MDU_Busy, bus.EXE_MDU_Done, bus.EXE_HI, bus.EXE_LO}, 0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("mult_after_rst", 3'd0, 32'd3, 32'd5, 64'd15, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
